// File: rtl/rf_1p_arb_if.sv
// Bundle of the two requester ports, the clear control and the rf_1p-style memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface rf_1p_arb_if #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
);
    logic                  clr_i;
    logic                  clr_busy_o;

    logic                  a_req_i;
    logic                  a_we_i;
    logic [Addr_Width-1:0] a_addr_i;
    logic [Word_Width-1:0] a_data_i;
    logic                  a_gnt_o;
    logic                  a_rvld_o;

    logic                  b_req_i;
    logic                  b_we_i;
    logic [Addr_Width-1:0] b_addr_i;
    logic [Word_Width-1:0] b_data_i;
    logic                  b_gnt_o;
    logic                  b_rvld_o;

    logic [Word_Width-1:0] rdata_o;

    logic                  mem_cen_o;
    logic                  mem_wen_o;
    logic [Addr_Width-1:0] mem_addr_o;
    logic [Word_Width-1:0] mem_data_o;
    logic [Word_Width-1:0] mem_data_i;

    modport slave (
        input  clr_i,
        input  a_req_i, a_we_i, a_addr_i, a_data_i,
        input  b_req_i, b_we_i, b_addr_i, b_data_i,
        input  mem_data_i,
        output clr_busy_o,
        output a_gnt_o, a_rvld_o,
        output b_gnt_o, b_rvld_o,
        output rdata_o,
        output mem_cen_o, mem_wen_o, mem_addr_o, mem_data_o
    );

    modport master (
        output clr_i,
        output a_req_i, a_we_i, a_addr_i, a_data_i,
        output b_req_i, b_we_i, b_addr_i, b_data_i,
        output mem_data_i,
        input  clr_busy_o,
        input  a_gnt_o, a_rvld_o,
        input  b_gnt_o, b_rvld_o,
        input  rdata_o,
        input  mem_cen_o, mem_wen_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/rf_1p_arb.sv
// Two-requester round-robin arbiter in front of a single-port register file,
// with a full-depth zero-fill sequencer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate A/B requests, one memory access per cycle
// ST_CLEAR | write zero to address cnt_q every cycle, requests held off
module rf_1p_arb #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
) (
    input  logic         clk,
    input  logic         rst,
    rf_1p_arb_if.slave   bus
);
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [Addr_Width-1:0] CntLast = '1;

    state_t                state_q, state_d;
    logic [Addr_Width-1:0] cnt_q, cnt_d;
    logic                  b_last_q, b_last_d;
    logic                  a_rvld_q, b_rvld_q;
    logic                  a_win, b_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            b_last_q <= 1'b1;
            a_rvld_q <= 1'b0;
            b_rvld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_last_q <= b_last_d;
            a_rvld_q <= a_win & ~bus.a_we_i;
            b_rvld_q <= b_win & ~bus.b_we_i;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        b_last_d       = b_last_q;
        a_win          = 1'b0;
        b_win          = 1'b0;
        bus.mem_cen_o  = 1'b1;
        bus.mem_wen_o  = 1'b1;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;

        case (state_q)
            ST_IDLE: begin
                // rst gating keeps the memory port quiet while reset is held
                if (!rst) begin
                    a_win = bus.a_req_i & (~bus.b_req_i | b_last_q);
                    b_win = bus.b_req_i & ~a_win;
                end
                if (a_win) begin
                    bus.mem_cen_o  = 1'b0;
                    bus.mem_wen_o  = ~bus.a_we_i;
                    bus.mem_addr_o = bus.a_addr_i;
                    bus.mem_data_o = bus.a_we_i ? bus.a_data_i : '0;
                end else if (b_win) begin
                    bus.mem_cen_o  = 1'b0;
                    bus.mem_wen_o  = ~bus.b_we_i;
                    bus.mem_addr_o = bus.b_addr_i;
                    bus.mem_data_o = bus.b_we_i ? bus.b_data_i : '0;
                end
                if (a_win || b_win) begin
                    b_last_d = b_win;
                end
                if (bus.clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                bus.mem_cen_o  = 1'b0;
                bus.mem_wen_o  = 1'b0;
                bus.mem_addr_o = cnt_q;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.a_gnt_o    = a_win;
    assign bus.b_gnt_o    = b_win;
    assign bus.a_rvld_o   = a_rvld_q;
    assign bus.b_rvld_o   = b_rvld_q;
    assign bus.clr_busy_o = (state_q == ST_CLEAR);
    assign bus.rdata_o    = bus.mem_data_i;
endmodule

// File: doc/rf_1p_arb.md
RF_1P_ARB -- requirements
Module: rf_1p_arb

Interface
REQ-001 Parameter Word_Width, default 32, SHALL set the data word width.
REQ-002 Parameter Addr_Width, default 8, SHALL set the address width; depth is 2^Addr_Width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 clr_i  input  1  SHALL request a zero-fill of the whole memory.
REQ-006 clr_busy_o  output  1  SHALL be high while zero-fill runs.
REQ-007 a_req_i / b_req_i  input  1  SHALL be the per-requester access requests.
REQ-008 a_we_i / b_we_i  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-009 a_addr_i / b_addr_i  input  Addr_Width  SHALL be the requester addresses.
REQ-010 a_data_i / b_data_i  input  Word_Width  SHALL be the requester write data.
REQ-011 a_gnt_o / b_gnt_o  output  1  SHALL mark the cycle in which the request is issued to memory.
REQ-012 a_rvld_o / b_rvld_o  output  1  SHALL mark valid read data on rdata_o for that requester.
REQ-013 rdata_o  output  Word_Width  SHALL carry the shared read data.
REQ-014 mem_cen_o, mem_wen_o  output  1 each  SHALL be the rf_1p-style chip and write enables, both active low.
REQ-015 mem_addr_o  output  Addr_Width  SHALL be the memory address.
REQ-016 mem_data_o  output  Word_Width  SHALL be the memory write data.
REQ-017 mem_data_i  input  Word_Width  SHALL be the memory read data; it is registered inside the memory and holds between reads.

Function
REQ-018 The FSM SHALL have two states, IDLE and CLEAR.
REQ-019 In IDLE, the arbiter SHALL grant at most one requester per cycle; gnt, mem_cen_o, mem_wen_o, mem_addr_o and mem_data_o SHALL be combinational from the req inputs and the priority pointer.
REQ-020 Single request: it SHALL be granted in the same cycle.
REQ-021 Both requesting: the requester not granted most recently SHALL win.
REQ-022 The pointer SHALL update only on a grant cycle.
REQ-023 The pointer reset value SHALL be "B last", so A wins the first tie.
REQ-024 Granted write: mem_cen_o=0, mem_wen_o=0, mem_addr_o/mem_data_o = the winner's addr/data.
REQ-025 Granted read: mem_cen_o=0, mem_wen_o=1, mem_addr_o = the winner's address.
REQ-026 No grant: mem_cen_o=1 and mem_wen_o=1; mem_addr_o and mem_data_o SHALL be 0.
REQ-027 Requesters SHALL hold req/we/addr/data stable until granted; an ungranted request SHALL be retried every cycle with no internal queuing.
REQ-028 x_rvld_o SHALL be a register set for exactly one cycle, the cycle after a read grant to x; a_rvld_o and b_rvld_o SHALL never be high together.
REQ-029 rdata_o SHALL equal mem_data_i, giving read latency 1 cycle from grant.
REQ-030 Back-to-back reads, including reads alternating A/B, SHALL sustain one read per cycle.
REQ-031 clr_i=1 in IDLE: requests SHALL still be arbitrated in that cycle, and the FSM SHALL enter CLEAR next cycle with the counter at 0.
REQ-032 In CLEAR: mem_cen_o=0, mem_wen_o=0, mem_addr_o=counter, mem_data_o=0; both gnt outputs SHALL be 0; the counter SHALL increment each cycle.
REQ-033 CLEAR exit: the cycle writing address 2^Addr_Width-1 SHALL be the last CLEAR cycle; the FSM SHALL return to IDLE and the counter SHALL wrap to 0.
REQ-034 CLEAR length SHALL be exactly 2^Addr_Width cycles.
REQ-035 clr_busy_o SHALL be registered and equal to (state==CLEAR).
REQ-036 clr_i asserted during CLEAR SHALL be ignored; it SHALL neither restart nor extend the fill.
REQ-037 A read granted in the cycle clr_i is sampled SHALL still produce its rvld in the first CLEAR cycle with correct data.

Reset
REQ-038 Asserting rst SHALL immediately force: state=IDLE, counter=0, pointer="B last", a_rvld_o=b_rvld_o=0, clr_busy_o=0.
REQ-039 rst during CLEAR SHALL abort the fill; memory contents are then undefined.
REQ-040 While rst is high, gnt outputs SHALL be 0 and mem_cen_o and mem_wen_o SHALL be 1.

Verification
REQ-041 Write then read: A writes 0xDEADBEEF at 0x10; B reads 0x10 next cycle -> b_gnt_o same cycle, b_rvld_o one cycle later, rdata_o=0xDEADBEEF.
REQ-042 Tie handling: A and B both request continuously for 6 cycles from reset -> grants A,B,A,B,A,B.
REQ-043 Single requester: B alone for 3 cycles, then A and B together -> A wins.
REQ-044 Zero-fill: fill all 256 addresses with 0xFFFFFFFF, pulse clr_i -> clr_busy_o high exactly 256 cycles, no grants during it, then reads of 0x00, 0x7F and 0xFF return 0.
REQ-045 Clear overlap: read granted in the clr_i cycle -> rvld in the next cycle with correct data; a second clr_i pulse mid-CLEAR leaves total busy at 256 cycles.
REQ-046 Reset mid-clear: assert rst at fill count 100 -> clr_busy_o low immediately, state IDLE, next tie grants A.
